// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer
// Layer-level scheduler in front of the tinyNPU core. The host queues layer
// descriptors (op mode, output-layer flag, shape/slice/depth configuration)
// into a small FIFO. Layers are issued to the NPU one at a time: the config is
// held stable with mode NOP for SETUP_CYC cycles, the mode is then asserted
// until the NPU reports done (or the watchdog expires), and a one-cycle
// terminate pulse closes the layer. Abort flushes everything.
//
// Ports
//   i_clk, i_n_reset      clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready/i_cmd_data
//                         descriptor push handshake; data layout
//                         [1:0] op_mode, [2] output_layer, [126:3] cfg
//   i_abort               level; flush queue and stop the current layer
//   i_npu_done            tinyNPU o_done
//   o_op_mode             tinyNPU i_op_mode (00 NOP, 01 POOL, 10 MVM, 11 CONV)
//   o_terminate           tinyNPU i_terminate, one-cycle pulse
//   o_output_layer        tinyNPU i_output_layer
//   o_cfg                 tinyNPU shape/slice/output_depth inputs
//   o_busy                sequencer active or descriptors pending
//   o_layer_done          pulse per completed or skipped layer
//   o_all_done            pulse when a layer flagged as output layer completes
//   o_timeout             sticky watchdog flag, cleared by reset or abort
//   o_layer_count         completed layers, modulo 256
//   o_state               FSM state (IDLE 0, POP 1, SETUP 2, RUN 3, TERM 4, GAP 5)

module npu_layer_sequencer #(
    parameter int CMD_DEPTH   = 4,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16,
    parameter int DESC_W      = 127
) (
    input  logic              i_clk,
    input  logic              i_n_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DESC_W-1:0] i_cmd_data,
    input  logic              i_abort,
    input  logic              i_npu_done,
    output logic [1:0]        o_op_mode,
    output logic              o_terminate,
    output logic              o_output_layer,
    output logic [DESC_W-4:0] o_cfg,
    output logic              o_busy,
    output logic              o_layer_done,
    output logic              o_all_done,
    output logic              o_timeout,
    output logic [7:0]        o_layer_count,
    output logic [2:0]        o_state
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int SET_W = $clog2(SETUP_CYC + 1);
    localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic WD_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_SETUP = 3'd2,
        S_RUN   = 3'd3,
        S_TERM  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t state, next_state;

    logic [DESC_W-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [DESC_W-1:0] fifo_head;

    logic [1:0]        mode_q;
    logic [SET_W-1:0]  setup_cnt;
    logic [CNT_W-1:0]  wd_cnt;
    logic              done_q;
    logic              done_edge;
    logic              wd_hit;
    // Remembers that TERM was entered because of an abort, so a one-cycle
    // abort pulse still sends TERM to IDLE instead of GAP.
    logic              abort_q;

    assign fifo_full   = (fifo_cnt == (PTR_W+1)'(CMD_DEPTH));
    assign fifo_empty  = (fifo_cnt == '0);
    assign o_cmd_ready = !fifo_full && !i_abort;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state == S_POP);
    assign fifo_head   = fifo_mem[rd_ptr];

    assign done_edge   = i_npu_done && !done_q;
    assign wd_hit      = WD_EN && (wd_cnt == WD_LAST);

    // Descriptor storage needs no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_cmd_data;
        end
    end

    // FIFO pointers and occupancy; abort empties the queue in one cycle.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (i_abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Layer datapath: latched descriptor, phase counters, status.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            o_cfg          <= '0;
            o_output_layer <= 1'b0;
            mode_q         <= 2'b00;
            setup_cnt      <= '0;
            wd_cnt         <= '0;
            done_q         <= 1'b0;
            o_timeout      <= 1'b0;
            o_layer_count  <= 8'd0;
            abort_q        <= 1'b0;
        end else begin
            done_q <= i_npu_done;

            if (pop && !i_abort) begin
                o_cfg          <= fifo_head[DESC_W-1:3];
                o_output_layer <= fifo_head[2];
                mode_q         <= fifo_head[1:0];
            end

            setup_cnt <= (state == S_SETUP) ? setup_cnt + SET_W'(1) : '0;
            wd_cnt    <= (state == S_RUN)   ? wd_cnt + CNT_W'(1)    : '0;

            // A done edge in the same cycle as expiry counts as a normal finish.
            if (i_abort) begin
                o_timeout <= 1'b0;
            end else if (state == S_RUN && !done_edge && wd_hit) begin
                o_timeout <= 1'b1;
            end

            if (state == S_GAP && !i_abort) begin
                o_layer_count <= o_layer_count + 8'd1;
            end

            if (i_abort && (state == S_SETUP || state == S_RUN)) begin
                abort_q <= 1'b1;
            end else if (state == S_TERM) begin
                abort_q <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !i_abort) next_state = S_POP;
            end
            S_POP: begin
                if (i_abort)                     next_state = S_IDLE;
                else if (fifo_head[1:0] == 2'b00) next_state = S_GAP;
                else                             next_state = S_SETUP;
            end
            S_SETUP: begin
                if (i_abort)                     next_state = S_TERM;
                else if (setup_cnt == SETUP_LAST) next_state = S_RUN;
            end
            S_RUN: begin
                if (i_abort || done_edge || wd_hit) next_state = S_TERM;
            end
            S_TERM: begin
                if (i_abort || abort_q) next_state = S_IDLE;
                else                    next_state = S_GAP;
            end
            S_GAP: begin
                if (i_abort)          next_state = S_IDLE;
                else if (!fifo_empty) next_state = S_POP;
                else                  next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The NPU only sees a real mode while a layer is running; everywhere else
    // it is held at NOP so config changes never reach an active core.
    always_comb begin
        o_op_mode    = (state == S_RUN) ? mode_q : 2'b00;
        o_terminate  = (state == S_TERM);
        o_layer_done = (state == S_GAP) && !i_abort;
        o_all_done   = (state == S_GAP) && !i_abort && o_output_layer;
        o_busy       = (state != S_IDLE) || !fifo_empty;
        o_state      = state;
    end

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// tb_npu_layer_sequencer
// Directed bench for npu_layer_sequencer with the watchdog shortened to 64
// cycles. Inputs change and outputs are sampled on the falling clock edge.

module tb_npu_layer_sequencer;

    localparam int TIMEOUT = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP   = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_TERM  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic         i_clk = 1'b0;
    logic         i_n_reset;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [126:0] i_cmd_data;
    logic         i_abort;
    logic         i_npu_done;
    logic [1:0]   o_op_mode;
    logic         o_terminate;
    logic         o_output_layer;
    logic [123:0] o_cfg;
    logic         o_busy;
    logic         o_layer_done;
    logic         o_all_done;
    logic         o_timeout;
    logic [7:0]   o_layer_count;
    logic [2:0]   o_state;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [123:0] conv_cfg;
    logic [1:0]   t2_mode [5];
    logic         t2_out  [5];

    always #5 i_clk = ~i_clk;

    npu_layer_sequencer #(
        .CMD_DEPTH   (4),
        .SETUP_CYC   (2),
        .TIMEOUT_CYC (TIMEOUT),
        .CNT_W       (16),
        .DESC_W      (127)
    ) dut (
        .i_clk          (i_clk),
        .i_n_reset      (i_n_reset),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_data     (i_cmd_data),
        .i_abort        (i_abort),
        .i_npu_done     (i_npu_done),
        .o_op_mode      (o_op_mode),
        .o_terminate    (o_terminate),
        .o_output_layer (o_output_layer),
        .o_cfg          (o_cfg),
        .o_busy         (o_busy),
        .o_layer_done   (o_layer_done),
        .o_all_done     (o_all_done),
        .o_timeout      (o_timeout),
        .o_layer_count  (o_layer_count),
        .o_state        (o_state)
    );

    function automatic logic [126:0] make_desc(input logic [1:0] mode, input logic out_l,
                                               input logic [123:0] cfg);
        return {cfg, out_l, mode};
    endfunction

    function automatic logic [123:0] cfg_of(input int k);
        return {4{31'(k * 7 + 3)}};
    endfunction

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one descriptor, waiting (bounded) for the FIFO to accept it.
    task automatic apply_stimulus(input logic [126:0] desc);
        int waited;
        waited = 0;
        i_cmd_data  = desc;
        i_cmd_valid = 1'b1;
        while (!o_cmd_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!o_cmd_ready) check_output("push_ready", {127'd0, o_cmd_ready}, 128'd1);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_state == target) break;
            tick();
        end
        check_output(tag, {125'd0, o_state}, {125'd0, target});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!o_busy) break;
            tick();
        end
        check_output(tag, {127'd0, o_busy}, 128'd0);
    endtask

    // Runs one non-NOP layer with the NPU reporting done after lat RUN cycles;
    // returns with the sequencer in GAP.
    task automatic run_layer(input logic [1:0] mode, input logic [123:0] cfg,
                             input logic out_l, input int lat);
        wait_state(ST_RUN, "layer_run_entry", 40);
        check_output("layer_mode", {126'd0, o_op_mode}, {126'd0, mode});
        check_output("layer_cfg", {4'd0, o_cfg}, {4'd0, cfg});
        check_output("layer_out_flag", {127'd0, o_output_layer}, {127'd0, out_l});
        repeat (lat - 1) tick();
        i_npu_done = 1'b1;
        tick();
        check_output("layer_terminate", {127'd0, o_terminate}, 128'd1);
        check_output("layer_term_nop", {126'd0, o_op_mode}, 128'd0);
        i_npu_done = 1'b0;
        tick();
        check_output("layer_done", {127'd0, o_layer_done}, 128'd1);
        check_output("layer_all_done", {127'd0, o_all_done}, {127'd0, out_l});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        i_n_reset   = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_data  = '0;
        i_abort     = 1'b0;
        i_npu_done  = 1'b0;
        conv_cfg = {12'd9, 8'd0, 8'd1, 8'd4, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2,
                    8'd3, 8'd3, 8'd4, 8'd1, 8'd4, 8'd4};
        t2_mode[0] = 2'd3; t2_mode[1] = 2'd2; t2_mode[2] = 2'd1; t2_mode[3] = 2'd3; t2_mode[4] = 2'd2;
        t2_out[0]  = 1'b0; t2_out[1]  = 1'b0; t2_out[2]  = 1'b0; t2_out[3]  = 1'b0; t2_out[4]  = 1'b1;

        // Reset state
        repeat (2) tick();
        check_output("rst_state", {125'd0, o_state}, 128'd0);
        check_output("rst_mode", {126'd0, o_op_mode}, 128'd0);
        check_output("rst_busy", {127'd0, o_busy}, 128'd0);
        check_output("rst_cfg", {4'd0, o_cfg}, 128'd0);
        check_output("rst_count", {120'd0, o_layer_count}, 128'd0);
        check_output("rst_timeout", {127'd0, o_timeout}, 128'd0);
        i_n_reset = 1'b1;
        tick();

        // Single CONV layer, exact timeline
        $display("[TB] single CONV layer");
        apply_stimulus(make_desc(2'd3, 1'b1, conv_cfg));
        check_output("t1_idle_busy", {127'd0, o_busy}, 128'd1);
        tick();
        check_output("t1_pop", {125'd0, o_state}, {125'd0, ST_POP});
        tick();
        check_output("t1_setup", {125'd0, o_state}, {125'd0, ST_SETUP});
        check_output("t1_setup_nop", {126'd0, o_op_mode}, 128'd0);
        check_output("t1_setup_cfg", {4'd0, o_cfg}, {4'd0, conv_cfg});
        tick();
        check_output("t1_setup2", {125'd0, o_state}, {125'd0, ST_SETUP});
        tick();
        check_output("t1_run_mode", {126'd0, o_op_mode}, 128'd3);
        repeat (39) tick();
        check_output("t1_still_run", {125'd0, o_state}, {125'd0, ST_RUN});
        i_npu_done = 1'b1;
        tick();
        check_output("t1_terminate", {127'd0, o_terminate}, 128'd1);
        check_output("t1_term_state", {125'd0, o_state}, {125'd0, ST_TERM});
        i_npu_done = 1'b0;
        tick();
        check_output("t1_layer_done", {127'd0, o_layer_done}, 128'd1);
        check_output("t1_all_done", {127'd0, o_all_done}, 128'd1);
        tick();
        check_output("t1_count", {120'd0, o_layer_count}, 128'd1);
        check_output("t1_idle", {125'd0, o_state}, 128'd0);
        check_output("t1_cfg_held", {4'd0, o_cfg}, {4'd0, conv_cfg});

        // Five back-to-back descriptors with a slow NPU
        $display("[TB] queued layers in order");
        for (int k = 0; k < 5; k++) apply_stimulus(make_desc(t2_mode[k], t2_out[k], cfg_of(k)));
        check_output("t2_ready_full", {127'd0, o_cmd_ready}, 128'd0);
        for (int k = 0; k < 5; k++) run_layer(t2_mode[k], cfg_of(k), t2_out[k], 20);
        tick();
        check_output("t2_count", {120'd0, o_layer_count}, 128'd6);

        // Watchdog expiry, then the next descriptor runs normally
        $display("[TB] watchdog");
        apply_stimulus(make_desc(2'd3, 1'b0, cfg_of(20)));
        apply_stimulus(make_desc(2'd2, 1'b1, cfg_of(21)));
        wait_state(ST_RUN, "t3_run", 40);
        repeat (TIMEOUT - 1) tick();
        check_output("t3_before_to", {127'd0, o_timeout}, 128'd0);
        check_output("t3_before_state", {125'd0, o_state}, {125'd0, ST_RUN});
        tick();
        check_output("t3_timeout", {127'd0, o_timeout}, 128'd1);
        check_output("t3_terminate", {127'd0, o_terminate}, 128'd1);
        tick();
        check_output("t3_gap_done", {127'd0, o_layer_done}, 128'd1);
        run_layer(2'd2, cfg_of(21), 1'b1, 5);
        check_output("t3_sticky", {127'd0, o_timeout}, 128'd1);
        tick();
        check_output("t3_count", {120'd0, o_layer_count}, 128'd8);

        // Abort in RUN with two descriptors still queued
        $display("[TB] abort");
        for (int k = 30; k < 33; k++) apply_stimulus(make_desc(2'd1, 1'b0, cfg_of(k)));
        wait_state(ST_RUN, "t4_run", 40);
        i_abort = 1'b1;
        #1;
        check_output("t4_ready_abort", {127'd0, o_cmd_ready}, 128'd0);
        tick();
        i_abort = 1'b0;
        check_output("t4_terminate", {127'd0, o_terminate}, 128'd1);
        check_output("t4_to_cleared", {127'd0, o_timeout}, 128'd0);
        tick();
        check_output("t4_idle", {125'd0, o_state}, 128'd0);
        check_output("t4_no_done", {127'd0, o_layer_done}, 128'd0);
        check_output("t4_empty", {127'd0, o_busy}, 128'd0);
        check_output("t4_count", {120'd0, o_layer_count}, 128'd8);
        repeat (3) tick();
        check_output("t4_stays_idle", {125'd0, o_state}, 128'd0);

        // Done edge on the same cycle the watchdog would expire
        $display("[TB] done vs timeout");
        apply_stimulus(make_desc(2'd3, 1'b0, cfg_of(40)));
        wait_state(ST_RUN, "t5_run", 40);
        repeat (TIMEOUT - 1) tick();
        i_npu_done = 1'b1;
        tick();
        check_output("t5_term", {125'd0, o_state}, {125'd0, ST_TERM});
        check_output("t5_no_timeout", {127'd0, o_timeout}, 128'd0);
        i_npu_done = 1'b0;
        tick();
        check_output("t5_done", {127'd0, o_layer_done}, 128'd1);
        tick();
        check_output("t5_count", {120'd0, o_layer_count}, 128'd9);

        // Done already high when RUN starts is not an edge
        $display("[TB] done level on entry");
        apply_stimulus(make_desc(2'd1, 1'b0, cfg_of(41)));
        wait_state(ST_SETUP, "t6_setup", 40);
        i_npu_done = 1'b1;
        wait_state(ST_RUN, "t6_run", 40);
        repeat (3) tick();
        check_output("t6_no_edge", {125'd0, o_state}, {125'd0, ST_RUN});
        i_npu_done = 1'b0;
        tick();
        i_npu_done = 1'b1;
        tick();
        check_output("t6_terminate", {127'd0, o_terminate}, 128'd1);
        i_npu_done = 1'b0;
        tick();
        tick();
        check_output("t6_count", {120'd0, o_layer_count}, 128'd10);

        // NOP descriptor is skipped without terminate
        $display("[TB] NOP skip");
        apply_stimulus(make_desc(2'd0, 1'b0, cfg_of(50)));
        tick();
        check_output("t7_pop", {125'd0, o_state}, {125'd0, ST_POP});
        tick();
        check_output("t7_gap", {125'd0, o_state}, {125'd0, ST_GAP});
        check_output("t7_done", {127'd0, o_layer_done}, 128'd1);
        check_output("t7_no_term", {127'd0, o_terminate}, 128'd0);
        check_output("t7_mode", {126'd0, o_op_mode}, 128'd0);
        check_output("t7_cfg", {4'd0, o_cfg}, {4'd0, cfg_of(50)});
        tick();
        check_output("t7_count", {120'd0, o_layer_count}, 128'd11);

        // Asynchronous reset in the middle of a layer
        $display("[TB] reset mid-run");
        apply_stimulus(make_desc(2'd3, 1'b0, cfg_of(60)));
        apply_stimulus(make_desc(2'd2, 1'b0, cfg_of(61)));
        wait_state(ST_RUN, "t8_run", 40);
        i_n_reset = 1'b0;
        #1;
        check_output("t8_mode", {126'd0, o_op_mode}, 128'd0);
        check_output("t8_state", {125'd0, o_state}, 128'd0);
        check_output("t8_busy", {127'd0, o_busy}, 128'd0);
        check_output("t8_cfg", {4'd0, o_cfg}, 128'd0);
        check_output("t8_count", {120'd0, o_layer_count}, 128'd0);
        tick();
        i_n_reset = 1'b1;
        tick();
        check_output("t8_flushed", {127'd0, o_busy}, 128'd0);
        apply_stimulus(make_desc(2'd2, 1'b1, cfg_of(62)));
        run_layer(2'd2, cfg_of(62), 1'b1, 7);
        tick();
        check_output("t8_resume_count", {120'd0, o_layer_count}, 128'd1);

        // Layer counter wraps 255 -> 0
        $display("[TB] counter wrap");
        for (int k = 0; k < 254; k++) apply_stimulus(make_desc(2'd0, 1'b0, cfg_of(k)));
        wait_idle("t9_idle_a", 100);
        check_output("t9_count_255", {120'd0, o_layer_count}, 128'd255);
        apply_stimulus(make_desc(2'd0, 1'b0, cfg_of(7)));
        wait_idle("t9_idle_b", 100);
        check_output("t9_count_wrap", {120'd0, o_layer_count}, 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
